// File: rtl/memory_write_control.sv
// Packs four DATA_WIDTH pixels into each MEM_WIDTH word and writes the words linearly into the frame memory.
// Optional FMEM_WR_LINE_PAD_EN: each line ends with a zero-padded partial write, so every line starts word-aligned.
module memory_write_control #(
    parameter int DATA_WIDTH = 24,
    parameter int MEM_WIDTH  = DATA_WIDTH * 4,
    parameter int ADDR_DEPTH = 512 * 512 / 4,
    parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  rst,
    input  logic                  i_vsync,
    input  logic                  i_hsync,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [10:0]           i_vres,
    output logic                  o_csn,
    output logic                  o_wen,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [MEM_WIDTH-1:0]  o_wdata,
    output logic                  o_frame_done,
    output logic                  o_ovf
);
    typedef enum logic [1:0] {IDLE, ARMED, PACK, FLUSH} state_t;

    state_t                  state_q;
    logic                    vsync_q, de_q;
    logic [1:0]              pix_idx_q;
    logic [3*DATA_WIDTH-1:0] pend_q;
    logic [10:0]             line_cnt_q, line_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, waddr_q;
    logic                    full_q;
    logic                    csn_q, wen_q, frame_done_q, ovf_q;
    logic [MEM_WIDTH-1:0]    wdata_q, wdata_d;
    logic                    vs_edge, de_fall, pix_take, word_full;
    logic                    line_end, frame_end, partial, pad_wr, wr_req;
    logic                    unused_hsync;

    assign unused_hsync = i_hsync;

    always_comb begin
        vs_edge    = i_vsync & ~vsync_q;
        de_fall    = ~i_de & de_q;
        pix_take   = ~vs_edge & i_de & ((state_q == ARMED) | (state_q == PACK));
        word_full  = pix_take & (pix_idx_q == 2'd3);
        line_cnt_d = line_cnt_q + 11'd1;
        line_end   = ~vs_edge & de_fall & (state_q == PACK);
        frame_end  = line_end & (line_cnt_d == i_vres);
        partial    = (pix_idx_q != 2'd0);
`ifdef FMEM_WR_LINE_PAD_EN
        pad_wr     = line_end & partial;
`else
        pad_wr     = frame_end & partial;
`endif
        wr_req     = word_full | pad_wr;
        wdata_d    = word_full ? {i_data, pend_q} : {{DATA_WIDTH{1'b0}}, pend_q};
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            de_q         <= 1'b0;
            pix_idx_q    <= 2'd0;
            pend_q       <= '0;
            line_cnt_q   <= '0;
            addr_q       <= '0;
            full_q       <= 1'b0;
            csn_q        <= 1'b1;
            wen_q        <= 1'b1;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            vsync_q      <= i_vsync;
            de_q         <= i_de;
            csn_q        <= 1'b1;
            wen_q        <= 1'b1;
            frame_done_q <= 1'b0;
            if (vs_edge) begin
                // A new frame start always wins: drop partial data and rewind.
                state_q    <= ARMED;
                pix_idx_q  <= 2'd0;
                pend_q     <= '0;
                line_cnt_q <= '0;
                addr_q     <= '0;
                full_q     <= 1'b0;
                ovf_q      <= 1'b0;
            end else begin
                if (pix_take) begin
                    pix_idx_q <= pix_idx_q + 2'd1;
                    case (pix_idx_q)
                        2'd0:    pend_q[0 +: DATA_WIDTH]            <= i_data;
                        2'd1:    pend_q[DATA_WIDTH +: DATA_WIDTH]   <= i_data;
                        2'd2:    pend_q[2*DATA_WIDTH +: DATA_WIDTH] <= i_data;
                        default: pend_q                             <= '0;
                    endcase
                end
                if (pad_wr) begin
                    pix_idx_q <= 2'd0;
                    pend_q    <= '0;
                end
                // full_q marks that the last address is used; later writes are suppressed.
                if (wr_req) begin
                    if (full_q) begin
                        ovf_q <= 1'b1;
                    end else begin
                        csn_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        waddr_q <= addr_q;
                        wdata_q <= wdata_d;
                        if (addr_q == ADDR_WIDTH'(ADDR_DEPTH - 1)) full_q <= 1'b1;
                        else                                       addr_q <= addr_q + 1'b1;
                    end
                end
                case (state_q)
                    IDLE: ;
                    ARMED: if (pix_take) state_q <= PACK;
                    PACK: begin
                        if (line_end) begin
                            line_cnt_q <= line_cnt_d;
                            if (frame_end) begin
                                if (partial) begin
                                    state_q <= FLUSH;
                                end else begin
                                    frame_done_q <= 1'b1;
                                    state_q      <= IDLE;
                                end
                            end
                        end
                    end
                    FLUSH: begin
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_csn        = csn_q;
    assign o_wen        = wen_q;
    assign o_waddr      = waddr_q;
    assign o_wdata      = wdata_q;
    assign o_frame_done = frame_done_q;
    assign o_ovf        = ovf_q;
endmodule
